// File: rtl/load_store_unit.sv
// Load/store unit: aligns core byte/half/word accesses onto a Wishbone
// classic bus, with misalignment trapping, bus-error and timeout handling.
module load_store_unit #(
    parameter int BUS_ADDRESS_WIDTH = 32,
    parameter int BUS_DATA_WIDTH    = 32,
    parameter int TIMEOUT_CYCLES    = 15
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          request_valid,
    output logic                          request_ready,
    input  logic                          request_write,
    input  logic [1:0]                    request_size,
    input  logic                          request_unsigned,
    input  logic [31:0]                   request_address,
    input  logic [31:0]                   request_write_data,
    output logic                          response_valid,
    output logic                          response_error,
    output logic [31:0]                   response_read_data,
    output logic                          wb_cyc,
    output logic                          wb_stb,
    output logic                          wb_we,
    output logic [BUS_ADDRESS_WIDTH-1:0]  wb_adr,
    output logic [BUS_DATA_WIDTH/8-1:0]   wb_sel,
    output logic [BUS_DATA_WIDTH-1:0]     wb_dat_o,
    input  logic [BUS_DATA_WIDTH-1:0]     wb_dat_i,
    input  logic                          wb_ack,
    input  logic                          wb_err
);

    localparam int LANES = BUS_DATA_WIDTH / 8;
    localparam int OFFW  = $clog2(LANES);
    localparam int CW    = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TMO_LAST =
        (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUS,
        S_RESPOND
    } state_t;

    state_t                   state_q, state_d;
    logic                     cyc_q, cyc_d;
    logic                     we_q, we_d;
    logic [BUS_ADDRESS_WIDTH-1:0] adr_q, adr_d;
    logic [LANES-1:0]         sel_q, sel_d;
    logic [BUS_DATA_WIDTH-1:0] dat_q, dat_d;
    logic [1:0]               size_q, size_d;
    logic                     uns_q, uns_d;
    logic [OFFW-1:0]          off_q, off_d;
    logic                     err_q, err_d;
    logic [31:0]              rdata_q, rdata_d;
    logic [CW-1:0]            cnt_q, cnt_d;

    logic                     misaligned;
    logic [OFFW-1:0]          req_off;
    logic [LANES-1:0]         sel_base;
    logic [31:0]              wmask;
    logic [BUS_ADDRESS_WIDTH-1:0] req_adr;
    logic [LANES-1:0]         req_sel;
    logic [BUS_DATA_WIDTH-1:0] req_dat;
    logic [31:0]              rd_word;
    logic [31:0]              rd_ext;
    logic                     tmo;

    assign req_off = request_address[OFFW-1:0];
    assign req_adr = BUS_ADDRESS_WIDTH'({request_address[31:OFFW], {OFFW{1'b0}}});
    assign req_sel = sel_base << req_off;
    assign req_dat = BUS_DATA_WIDTH'(request_write_data & wmask) << {req_off, 3'b000};

    always_comb begin
        misaligned = 1'b0;
        sel_base   = '0;
        wmask      = '0;
        unique case (1'b1)
            request_size == 2'd0: begin
                sel_base = LANES'(4'h1);
                wmask    = 32'h0000_00FF;
            end
            request_size == 2'd1: begin
                sel_base   = LANES'(4'h3);
                wmask      = 32'h0000_FFFF;
                misaligned = request_address[0];
            end
            request_size == 2'd2: begin
                sel_base   = LANES'(4'hF);
                wmask      = 32'hFFFF_FFFF;
                misaligned = |request_address[1:0];
            end
            default: misaligned = 1'b1;
        endcase
    end

    // Bring the addressed lanes down to bit 0, then extend by access size.
    assign rd_word = 32'(wb_dat_i >> {off_q, 3'b000});

    always_comb begin
        rd_ext = rd_word;
        unique case (1'b1)
            size_q == 2'd0:
                rd_ext = {{24{~uns_q & rd_word[7]}}, rd_word[7:0]};
            size_q == 2'd1:
                rd_ext = {{16{~uns_q & rd_word[15]}}, rd_word[15:0]};
            default: rd_ext = rd_word;
        endcase
    end

    assign tmo = (TIMEOUT_CYCLES != 0) && (cnt_q >= TMO_LAST);

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        we_d    = we_q;
        adr_d   = adr_q;
        sel_d   = sel_q;
        dat_d   = dat_q;
        size_d  = size_q;
        uns_d   = uns_q;
        off_d   = off_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (request_valid) begin
                    size_d  = request_size;
                    uns_d   = request_unsigned;
                    off_d   = req_off;
                    err_d   = misaligned;
                    rdata_d = '0;
                    cnt_d   = '0;
                    if (misaligned) begin
                        state_d = S_RESPOND;
                    end else begin
                        state_d = S_BUS;
                        cyc_d   = 1'b1;
                        we_d    = request_write;
                        adr_d   = req_adr;
                        sel_d   = req_sel;
                        dat_d   = req_dat;
                    end
                end
            end
            S_BUS: begin
                if (wb_err || wb_ack || tmo) begin
                    state_d = S_RESPOND;
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    adr_d   = '0;
                    sel_d   = '0;
                    dat_d   = '0;
                    // err beats ack; a timeout without ack is an error
                    err_d   = wb_err | ~wb_ack;
                    rdata_d = (wb_ack & ~wb_err & ~we_q) ? rd_ext : '0;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESPOND: begin
                state_d = S_IDLE;
                err_d   = 1'b0;
                rdata_d = '0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            sel_q   <= '0;
            dat_q   <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            off_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            sel_q   <= sel_d;
            dat_q   <= dat_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            off_q   <= off_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    assign request_ready      = (state_q == S_IDLE);
    assign response_valid     = (state_q == S_RESPOND);
    assign response_error     = response_valid & err_q;
    assign response_read_data = response_valid ? rdata_q : '0;
    assign wb_cyc             = cyc_q;
    assign wb_stb             = cyc_q;
    assign wb_we              = we_q;
    assign wb_adr             = adr_q;
    assign wb_sel             = sel_q;
    assign wb_dat_o           = dat_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: vector table, random accesses against a
// byte-lane reference model, and directed timeout/reset/64-bit sequences.
module tb_load_store_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        rv, rw, ru, rr, rsv, rse;
    logic [1:0]  rsz;
    logic [31:0] ra, rwd, rsd;
    logic        cyc, stb, we, ack, err;
    logic [31:0] adr, dato, dati;
    logic [3:0]  sel;

    logic        q_rv, q_rw, q_ru, q_rr, q_rsv, q_rse;
    logic [1:0]  q_rsz;
    logic [31:0] q_ra, q_rwd, q_rsd;
    logic        q_cyc, q_stb, q_we, q_ack, q_err;
    logic [31:0] q_adr;
    logic [7:0]  q_sel;
    logic [63:0] q_dato, q_dati;

    load_store_unit #(
        .BUS_ADDRESS_WIDTH(32), .BUS_DATA_WIDTH(32), .TIMEOUT_CYCLES(4)
    ) dut (
        .clock(clk), .reset(rst_n),
        .request_valid(rv), .request_ready(rr), .request_write(rw),
        .request_size(rsz), .request_unsigned(ru),
        .request_address(ra), .request_write_data(rwd),
        .response_valid(rsv), .response_error(rse),
        .response_read_data(rsd),
        .wb_cyc(cyc), .wb_stb(stb), .wb_we(we), .wb_adr(adr),
        .wb_sel(sel), .wb_dat_o(dato), .wb_dat_i(dati),
        .wb_ack(ack), .wb_err(err)
    );

    load_store_unit #(
        .BUS_ADDRESS_WIDTH(32), .BUS_DATA_WIDTH(64), .TIMEOUT_CYCLES(15)
    ) dut64 (
        .clock(clk), .reset(rst_n),
        .request_valid(q_rv), .request_ready(q_rr), .request_write(q_rw),
        .request_size(q_rsz), .request_unsigned(q_ru),
        .request_address(q_ra), .request_write_data(q_rwd),
        .response_valid(q_rsv), .response_error(q_rse),
        .response_read_data(q_rsd),
        .wb_cyc(q_cyc), .wb_stb(q_stb), .wb_we(q_we), .wb_adr(q_adr),
        .wb_sel(q_sel), .wb_dat_o(q_dato), .wb_dat_i(q_dati),
        .wb_ack(q_ack), .wb_err(q_err)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] bdat;
        int          wt;
        int          term;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic        mis;
        logic        err;
        logic [31:0] rd;
    } vec_t;

    function automatic vec_t mk(input logic w, input logic [1:0] s,
        input logic u, input logic [31:0] a, input logic [31:0] wd,
        input logic [31:0] bd, input int wt, input int term,
        input logic [3:0] es, input logic [31:0] ed, input logic em,
        input logic ee, input logic [31:0] er);
        vec_t v;
        v.we = w; v.sz = s; v.uns = u; v.addr = a; v.wdata = wd;
        v.bdat = bd; v.wt = wt; v.term = term; v.sel = es; v.dat = ed;
        v.mis = em; v.err = ee; v.rd = er;
        return v;
    endfunction

    // Reference: an access of N bytes is legal when the address is a
    // multiple of N; lanes are plain byte arithmetic on a 32-bit word.
    function automatic vec_t model(input vec_t v);
        vec_t r;
        int nb, off;
        longint unsigned m, x;
        r = v;
        nb = 1 << v.sz;
        off = int'(v.addr % 4);
        r.mis = (v.sz == 2'd3) || ((v.addr % nb) != 0);
        r.err = r.mis || (v.term != 0);
        m = (64'd1 << (8 * nb)) - 1;
        r.sel = 4'(((1 << nb) - 1) << off);
        r.dat = 32'((longint'(v.wdata) & m) << (8 * off));
        x = (longint'(v.bdat) >> (8 * off)) & m;
        if (!v.uns && nb < 4 && ((x >> (8 * nb - 1)) & 1) == 1)
            x = x | ~m;
        r.rd = (v.we || r.err) ? 32'h0 : 32'(x);
        return r;
    endfunction

    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        chk({tag, ".ready"}, rr, 1);
        rv = 1; rw = v.we; rsz = v.sz; ru = v.uns;
        ra = v.addr; rwd = v.wdata;
        @(negedge clk);
        rv = 0; rw = 1'($urandom); rsz = 2'($urandom);
        ra = $urandom; rwd = $urandom;
        if (v.mis) begin
            chk({tag, ".mis_valid"}, rsv, 1);
            chk({tag, ".mis_err"}, rse, 1);
            chk({tag, ".mis_cyc"}, cyc, 0);
            chk({tag, ".mis_data"}, rsd, 0);
        end else begin
            chk({tag, ".cyc"}, {cyc, stb}, 2'b11);
            chk({tag, ".we"}, we, v.we);
            chk({tag, ".adr"}, adr, v.addr & 32'hFFFF_FFFC);
            chk({tag, ".sel"}, sel, v.sel);
            if (v.we) chk({tag, ".dat"}, dato, v.dat);
            chk({tag, ".early"}, rsv, 0);
            dati = v.bdat;
            repeat (v.wt) @(negedge clk);
            chk({tag, ".hold"}, {cyc, adr, sel}, {1'b1, v.addr & 32'hFFFF_FFFC, v.sel});
            ack = (v.term != 1);
            err = (v.term != 0);
            @(negedge clk);
            ack = 0; err = 0; dati = $urandom;
            chk({tag, ".valid"}, rsv, 1);
            chk({tag, ".cyc_drop"}, cyc, 0);
            chk({tag, ".err"}, rse, v.err);
            chk({tag, ".rdata"}, rsd, v.rd);
        end
        @(negedge clk);
        chk({tag, ".pulse"}, rsv, 0);
    endtask

    task automatic q_access(input logic w, input logic [1:0] s,
        input logic u, input logic [31:0] a, input logic [31:0] wd,
        input logic [63:0] bd, input logic [31:0] eadr,
        input logic [7:0] esel, input logic [63:0] edat,
        input logic [31:0] erd, input string tag);
        @(negedge clk);
        q_rv = 1; q_rw = w; q_rsz = s; q_ru = u; q_ra = a; q_rwd = wd;
        @(negedge clk);
        q_rv = 0;
        chk({tag, ".cyc"}, q_cyc, 1);
        chk({tag, ".adr"}, q_adr, eadr);
        chk({tag, ".sel"}, q_sel, esel);
        if (w) chk({tag, ".dat"}, q_dato, edat);
        q_dati = bd; q_ack = 1;
        @(negedge clk);
        q_ack = 0;
        chk({tag, ".valid"}, q_rsv, 1);
        chk({tag, ".err"}, q_rse, 0);
        chk({tag, ".rdata"}, q_rsd, erd);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    vec_t tbl[14];
    vec_t rv_t;
    int cnt;

    initial begin
        rv = 0; rw = 0; rsz = 0; ru = 0; ra = 0; rwd = 0;
        dati = 0; ack = 0; err = 0;
        q_rv = 0; q_rw = 0; q_rsz = 0; q_ru = 0; q_ra = 0; q_rwd = 0;
        q_dati = 0; q_ack = 0; q_err = 0;

        tbl[0]  = mk(0, 2, 0, 32'h100, 0, 32'hDEADBEEF, 2, 0, 4'hF, 0, 0, 0, 32'hDEADBEEF);
        tbl[1]  = mk(0, 0, 0, 32'h103, 0, 32'h80000000, 0, 0, 4'h8, 0, 0, 0, 32'hFFFFFF80);
        tbl[2]  = mk(0, 0, 1, 32'h103, 0, 32'h80000000, 1, 0, 4'h8, 0, 0, 0, 32'h00000080);
        tbl[3]  = mk(0, 2, 0, 32'h102, 0, 0, 0, 0, 4'h0, 0, 1, 1, 0);
        tbl[4]  = mk(0, 1, 0, 32'h101, 0, 0, 0, 0, 4'h0, 0, 1, 1, 0);
        tbl[5]  = mk(0, 3, 0, 32'h100, 0, 0, 0, 0, 4'h0, 0, 1, 1, 0);
        tbl[6]  = mk(1, 1, 0, 32'h102, 32'h1234ABCD, 0, 0, 0, 4'hC, 32'hABCD0000, 0, 0, 0);
        tbl[7]  = mk(1, 0, 0, 32'h101, 32'hFFFFFF5A, 0, 1, 0, 4'h2, 32'h00005A00, 0, 0, 0);
        tbl[8]  = mk(0, 1, 0, 32'h102, 0, 32'h80011234, 0, 0, 4'hC, 0, 0, 0, 32'hFFFF8001);
        tbl[9]  = mk(0, 2, 0, 32'h200, 0, 32'h12345678, 1, 1, 4'hF, 0, 0, 1, 0);
        tbl[10] = mk(0, 2, 0, 32'h204, 0, 32'h12345678, 0, 2, 4'hF, 0, 0, 1, 0);
        tbl[11] = mk(1, 2, 0, 32'h300, 32'hCAFEF00D, 0, 2, 0, 4'hF, 32'hCAFEF00D, 0, 0, 0);
        tbl[12] = mk(1, 0, 0, 32'h003, 32'h00000077, 0, 0, 1, 4'h8, 32'h77000000, 0, 1, 0);
        tbl[13] = mk(0, 1, 1, 32'h100, 0, 32'h0000F00F, 1, 0, 4'h3, 0, 0, 0, 32'h0000F00F);

        #12;
        chk("rst.ready", rr, 1);
        chk("rst.resp", {rsv, rse, rsd}, 0);
        chk("rst.bus", {cyc, stb, we, adr, sel}, 0);
        chk("rst.dat", dato, 0);
        chk("rst.bus64", {q_cyc, q_stb, q_we, q_adr, q_sel, q_rsv}, 0);
        @(negedge clk);
        rst_n = 1;

        for (int i = 0; i < 14; i++)
            apply(tbl[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 150; i++) begin
            int t;
            rv_t.we = 1'($urandom);
            rv_t.sz = 2'($urandom);
            rv_t.uns = 1'($urandom);
            rv_t.addr = $urandom;
            rv_t.wdata = $urandom;
            rv_t.bdat = $urandom;
            rv_t.wt = int'($urandom_range(0, 2));
            t = int'($urandom_range(0, 7));
            rv_t.term = (t < 6) ? 0 : t - 5;
            rv_t = model(rv_t);
            apply(rv_t, $sformatf("rnd%0d", i));
        end

        // no ack: timeout after 4 bus cycles
        @(negedge clk);
        rv = 1; rw = 0; rsz = 2; ra = 32'h400;
        @(negedge clk);
        rv = 0;
        cnt = 0;
        for (int i = 0; i < 10 && cyc; i++) begin
            cnt++;
            @(negedge clk);
        end
        chk("tmo.cycles", cnt, 4);
        chk("tmo.valid", rsv, 1);
        chk("tmo.err", rse, 1);
        chk("tmo.data", rsd, 0);
        @(negedge clk);
        chk("tmo.pulse", rsv, 0);

        // reset mid-access drops cyc with no clock edge
        @(negedge clk);
        rv = 1; rw = 0; rsz = 2; ra = 32'h500;
        @(negedge clk);
        rv = 0;
        chk("rstmid.cyc_before", cyc, 1);
        #2 rst_n = 0;
        #1;
        chk("rstmid.cyc", {cyc, stb}, 0);
        chk("rstmid.ready", rr, 1);
        ack = 1; dati = 32'h11111111;
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("rstmid.novalid%0d", i), {rsv, cyc}, 0);
        end
        ack = 0;

        q_access(1, 1, 0, 32'h106, 32'h0000ABCD, 64'h0, 32'h100, 8'hC0,
                 64'hABCD000000000000, 0, "w64half");
        q_access(0, 0, 0, 32'h105, 0, 64'h00007F0000000000, 32'h100, 8'h20,
                 64'h0, 32'h0000007F, "w64byte");
        q_access(0, 2, 0, 32'h10C, 0, 64'h89ABCDEF00000000, 32'h108, 8'hF0,
                 64'h0, 32'h89ABCDEF, "w64word");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
